// File: rtl/turn_sequencer_if.sv
// Bundles the key input, board-write, renderer handshake and game-status signals of the turn sequencer.
// master = the sequencer; slave = keyboard, board datapath, renderer and end checker side.
interface turn_sequencer_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic [8:0] occ;
    logic       line3;
    logic       wr_en;
    logic [3:0] wr_pos;
    logic [1:0] wr_sym;
    logic       clr_board;
    logic       draw_req;
    logic       draw_ack;
    logic [1:0] turn;
    logic [1:0] result;
    logic       game_over;
    logic       move_err;
    logic       draw_fault;
    logic [3:0] move_cnt;

    modport master (
        input  key_valid, key_code, occ, line3, draw_ack,
        output wr_en, wr_pos, wr_sym, clr_board, draw_req,
               turn, result, game_over, move_err, draw_fault, move_cnt
    );

    modport slave (
        output key_valid, key_code, occ, line3, draw_ack,
        input  wr_en, wr_pos, wr_sym, clr_board, draw_req,
               turn, result, game_over, move_err, draw_fault, move_cnt
    );
endinterface

// File: rtl/turn_sequencer.sv
// Game-flow controller for Wild Misere Tic Tac Toe: validates key moves, writes the board, waits on the renderer, scores.
// Latency: symbol key to wr_en 1 cycle, to draw_req 2 cycles; backpressure: draw_req held until draw_ack or timeout, keys dropped while busy.
module turn_sequencer #(
    parameter int DRAW_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              resetn,
    turn_sequencer_if.master  bus
);
    localparam int CW = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(DRAW_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_POS,
        WAIT_SYM,
        WRITE,
        DRAW,
        CHECK,
        OVER
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    wr_pos_q, wr_pos_d;
    logic [1:0]    wr_sym_q, wr_sym_d;
    logic          wr_en_q, wr_en_d;
    logic          clr_board_q, clr_board_d;
    logic          draw_req_q, draw_req_d;
    logic [1:0]    turn_q, turn_d;
    logic [1:0]    result_q, result_d;
    logic          game_over_q, game_over_d;
    logic          move_err_q, move_err_d;
    logic          draw_fault_q, draw_fault_d;
    logic [3:0]    move_cnt_q, move_cnt_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic       is_pos, is_x, is_o, is_bs, is_new, occ_hit;
    logic [3:0] pos_val;

    // ASCII '1'..'9' carry the square number in their low nibble.
    assign pos_val = bus.key_code[3:0];
    assign is_pos  = (bus.key_code >= 8'h31) && (bus.key_code <= 8'h39);
    assign is_x    = (bus.key_code == 8'h58) || (bus.key_code == 8'h78);
    assign is_o    = (bus.key_code == 8'h4F) || (bus.key_code == 8'h6F);
    assign is_bs   = (bus.key_code == 8'h08);
    assign is_new  = (bus.key_code == 8'h4E) || (bus.key_code == 8'h6E);
    assign occ_hit = |(bus.occ & (9'd1 << (pos_val - 4'd1)));

    always_comb begin
        state_d      = state_q;
        wr_pos_d     = wr_pos_q;
        wr_sym_d     = wr_sym_q;
        wr_en_d      = 1'b0;
        clr_board_d  = 1'b0;
        draw_req_d   = draw_req_q;
        turn_d       = turn_q;
        result_d     = result_q;
        game_over_d  = game_over_q;
        move_err_d   = 1'b0;
        draw_fault_d = draw_fault_q;
        move_cnt_d   = move_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            WAIT_POS: begin
                if (bus.key_valid) begin
                    if (is_pos && !occ_hit) begin
                        wr_pos_d = pos_val;
                        state_d  = WAIT_SYM;
                    end else begin
                        move_err_d = 1'b1;
                    end
                end
            end
            WAIT_SYM: begin
                if (bus.key_valid) begin
                    if (is_x || is_o) begin
                        wr_sym_d = is_x ? 2'b01 : 2'b10;
                        wr_en_d  = 1'b1;
                        state_d  = WRITE;
                    end else if (is_bs) begin
                        state_d = WAIT_POS;
                    end else begin
                        move_err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                move_cnt_d = move_cnt_q + 4'd1;
                draw_req_d = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = DRAW;
            end
            DRAW: begin
                // A real ack wins over a timeout landing on the same cycle.
                if (bus.draw_ack) begin
                    draw_req_d = 1'b0;
                    state_d    = CHECK;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    draw_req_d   = 1'b0;
                    draw_fault_d = 1'b1;
                    state_d      = CHECK;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                // Misere rule: completing a line loses for the mover.
                if (bus.line3) begin
                    result_d    = (turn_q == 2'b01) ? 2'b10 : 2'b01;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else if (move_cnt_q == 4'd9) begin
                    result_d    = 2'b11;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else begin
                    turn_d  = (turn_q == 2'b01) ? 2'b10 : 2'b01;
                    state_d = WAIT_POS;
                end
            end
            OVER: begin
                if (bus.key_valid && is_new) begin
                    clr_board_d  = 1'b1;
                    turn_d       = 2'b01;
                    result_d     = 2'b00;
                    move_cnt_d   = 4'd0;
                    draw_fault_d = 1'b0;
                    game_over_d  = 1'b0;
                    state_d      = WAIT_POS;
                end
            end
            default: state_d = WAIT_POS;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= WAIT_POS;
            wr_pos_q     <= 4'd0;
            wr_sym_q     <= 2'b00;
            wr_en_q      <= 1'b0;
            clr_board_q  <= 1'b0;
            draw_req_q   <= 1'b0;
            turn_q       <= 2'b01;
            result_q     <= 2'b00;
            game_over_q  <= 1'b0;
            move_err_q   <= 1'b0;
            draw_fault_q <= 1'b0;
            move_cnt_q   <= 4'd0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_pos_q     <= wr_pos_d;
            wr_sym_q     <= wr_sym_d;
            wr_en_q      <= wr_en_d;
            clr_board_q  <= clr_board_d;
            draw_req_q   <= draw_req_d;
            turn_q       <= turn_d;
            result_q     <= result_d;
            game_over_q  <= game_over_d;
            move_err_q   <= move_err_d;
            draw_fault_q <= draw_fault_d;
            move_cnt_q   <= move_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_pos     = wr_pos_q;
    assign bus.wr_sym     = wr_sym_q;
    assign bus.clr_board  = clr_board_q;
    assign bus.draw_req   = draw_req_q;
    assign bus.turn       = turn_q;
    assign bus.result     = result_q;
    assign bus.game_over  = game_over_q;
    assign bus.move_err   = move_err_q;
    assign bus.draw_fault = draw_fault_q;
    assign bus.move_cnt   = move_cnt_q;
endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-flow controller for Wild Misere Tic Tac Toe. Turns ASCII key events into validated moves and writes them into the board-register datapath. It then hands each move to the VGA renderer through a req/ack handshake, samples the end-of-game checker, and alternates turns between player 1 and player 2. It sits between the keyboard/ASCII converter and the board datapath, renderer and end checker, replacing ad-hoc go-button sequencing.

## Interface
- DRAW_TIMEOUT, 1024: max cycles to wait for draw_ack before forcing progress (>=2).
- clock  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle pulse, key_code valid.
- key_code  in  8  ASCII code of pressed key.
- occ  in  9  square occupancy; bit i-1 set = square i non-empty.
- line3  in  1  checker flag: three identical letters in a row on current board.
- wr_en  out  1  one-cycle board write strobe.
- wr_pos  out  4  square 1..9 to write.
- wr_sym  out  2  symbol to write: 01 = X, 10 = O.
- clr_board  out  1  one-cycle pulse clearing all squares to 00.
- draw_req  out  1  renderer request; wr_pos/wr_sym are valid while high.
- draw_ack  in  1  renderer done.
- turn  out  2  mover: 01 = player 1, 10 = player 2.
- result  out  2  00 = in play, 01 = P1 wins, 10 = P2 wins, 11 = tie.
- game_over  out  1  high in OVER.
- move_err  out  1  one-cycle pulse on rejected key.
- draw_fault  out  1  sticky: a draw timed out.
- move_cnt  out  4  moves committed this game, 0..9.

## Operation
- Reset (async, resetn=0): state WAIT_POS, turn=01, result=00, move_cnt=0, wr_pos=0, wr_sym=00, all strobes/flags 0.
- Key decode: '1'..'9' (0x31–0x39) = position. 'X'/'x' (0x58/0x78) = 01. 'O'/'o' (0x4F/0x6F) = 10. Backspace 0x08 = cancel. 'N'/'n' (0x4E/0x6E) = new game.
- States:
  - WAIT_POS:
    - Free position latches wr_pos and goes to WAIT_SYM.
    - Occupied position (occ bit set): move_err, stay.
    - Any other key: move_err, stay.
  - WAIT_SYM:
    - Symbol latches wr_sym and goes to WRITE.
    - Cancel returns to WAIT_POS.
    - Other keys: move_err, stay.
  - WRITE: wr_en=1 for exactly one cycle; move_cnt+1; goes to DRAW.
  - DRAW:
    - draw_req=1 until draw_ack is sampled high, then goes to CHECK.
    - A timeout counter counts DRAW cycles. At DRAW_TIMEOUT it sets draw_fault and goes to CHECK.
  - CHECK:
    - line3=1: the mover loses. result = opposite of turn (turn 01 gives 10; turn 10 gives 01). Go to OVER.
    - Else move_cnt==9: result=11, go to OVER.
    - Else toggle turn, go to WAIT_POS.
  - OVER:
    - game_over=1; result held.
    - New-game key: clr_board pulse, turn=01, result=00, move_cnt=0, draw_fault=0, go to WAIT_POS.
    - Other keys are ignored without move_err.
- key_valid is ignored in WRITE, DRAW and CHECK; no queueing and no move_err.
- New-game key in WAIT_POS/WAIT_SYM: move_err, no restart (restart only from OVER).
- wr_pos/wr_sym hold last latched values until next latch; cleared only by reset.

## Timing
- All outputs registered.
- Symbol key sampled in cycle T: wr_en high in T+1; draw_req rises in T+2.
- Board registers update on the wr_en edge, so occ and line3 reflect the move by CHECK.
- draw_ack sampled on clock edges; ack may coincide with the first req cycle (min DRAW = 1 cycle). draw_req falls the cycle after ack is sampled.
- CHECK lasts exactly 1 cycle. Minimum symbol-key to next WAIT_POS = 4 cycles.
- Timeout: ack absent for DRAW_TIMEOUT DRAW cycles forces exit; an ack arriving later is ignored.
- Reset asserted mid-DRAW drops draw_req and wr_en asynchronously. clr_board is not issued; the datapath clears on its own reset.
- move_err is a single-cycle pulse coinciding with the cycle after the offending key_valid.

## Test plan
- Reset, keys '5' then 'x' -> wr_en pulse with wr_pos=5, wr_sym=01; draw_req until ack; turn becomes 10, move_cnt=1.
- occ bit4 set, key '5' in WAIT_POS -> move_err pulse, state stays WAIT_POS; then '5' fails again, '6' accepted.
- Keys '3', Backspace, '7', 'O' -> single write pos=7, sym=10; no write for 3.
- turn=01, line3=1 at CHECK -> result=10, game_over=1; key 'n' -> clr_board pulse, result=00, turn=01, move_cnt=0.
- Nine moves with line3=0 -> result=11 after ninth CHECK.
- draw_ack held 0, DRAW_TIMEOUT=8 -> draw_req low after 8 cycles, draw_fault=1, turn toggles; resetn pulse mid-DRAW -> all outputs to reset values immediately.
